serial_reversible_adder: RTL

//  Bit-serial adder built from reversible gates; the inverse operation of the 4-bit subtractor.

---
 rtl/serial_reversible_adder_pkg.sv | 34 +++
 rtl/feynman_gate.sv | 12 +
 rtl/peres_gate.sv | 15 +
 rtl/rev_full_adder_cell.sv | 29 ++
 rtl/serial_reversible_adder.sv | 115 +++++++++++
 5 files changed

// File: rtl/serial_reversible_adder_pkg.sv
// Shared state encodings and result-flag helper for the bit-serial reversible adder.
// The flag rule is common with the serial subtractor so both produce identical flags.
package serial_reversible_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic zero;
    logic parity;
    logic sign;
    logic overflow;
  } flags_t;

  // Overflow: operands agree in sign but the result sign differs from them.
  function automatic flags_t calc_flags(
    input logic sum_is_zero,
    input logic sum_parity,
    input logic sum_msb,
    input logic a_msb,
    input logic b_msb
  );
    flags_t f;
    f.zero     = sum_is_zero;
    f.parity   = sum_parity;
    f.sign     = sum_msb;
    f.overflow = (a_msb == b_msb) && (sum_msb != a_msb);
    return f;
  endfunction

endpackage

// File: rtl/feynman_gate.sv
// Feynman (controlled-NOT) reversible gate: p = a, q = a ^ b.
module feynman_gate (
  input  logic a,
  input  logic b,
  output logic p,
  output logic q
);

  assign p = a;
  assign q = a ^ b;

endmodule

// File: rtl/peres_gate.sv
// Peres reversible gate: p = a, q = a ^ b, r = (a & b) ^ c.
module peres_gate (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic p,
  output logic q,
  output logic r
);

  assign p = a;
  assign q = a ^ b;
  assign r = (a & b) ^ c;

endmodule

// File: rtl/rev_full_adder_cell.sv
// Combinational full adder made of two Peres gates and one Feynman gate.
module rev_full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic q1, r1, r2;
  logic unused_p0, unused_p1, unused_p2;

  peres_gate u_pg_half0 (
    .a(a), .b(b), .c(1'b0),
    .p(unused_p0), .q(q1), .r(r1)
  );

  peres_gate u_pg_half1 (
    .a(q1), .b(cin), .c(1'b0),
    .p(unused_p1), .q(s), .r(r2)
  );

  // r1 and r2 are never both 1, so XOR combines the two partial carries.
  feynman_gate u_fg_carry (
    .a(r1), .b(r2),
    .p(unused_p2), .q(cout)
  );

endmodule

// File: rtl/serial_reversible_adder.sv
// Bit-serial adder: one reversible full-adder cell, LSB first, with valid/ready handshakes.
// Result and flags register on the last bit and hold until the consumer accepts them.
module serial_reversible_adder
  import serial_reversible_adder_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int OUT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out,
  output logic                 carry,
  output logic                 zero,
  output logic                 parity,
  output logic                 sign,
  output logic                 overflow
);

  localparam int IDX_W = $clog2(WIDTH);

  state_t               state_reg, state_next;
  logic [WIDTH-1:0]     a_reg, b_reg, sum_reg, sum_next;
  logic                 carry_reg;
  logic [IDX_W-1:0]     bit_idx_reg;
  logic [OUT_WIDTH-1:0] out_reg;
  logic                 carry_out_reg;
  flags_t               flags_reg, flags_next;
  logic                 cell_s, cell_cout;
  logic                 last_bit;

  // Operands shift right, so bit 0 is always the bit at position bit_idx.
  rev_full_adder_cell u_cell (
    .a   (a_reg[0]),
    .b   (b_reg[0]),
    .cin (carry_reg),
    .s   (cell_s),
    .cout(cell_cout)
  );

  always_comb begin
    state_next = state_reg;
    in_ready   = rst_n && (state_reg == ST_IDLE);
    out_valid  = (state_reg == ST_DONE);
    last_bit   = (bit_idx_reg == IDX_W'(WIDTH - 1));
    // Sum enters at the MSB; after WIDTH shifts bit 0 sits at position 0.
    sum_next   = {cell_s, sum_reg[WIDTH-1:1]};
    // On the last bit a_reg[0]/b_reg[0] are the operand sign bits.
    flags_next = calc_flags(sum_next == '0, ^sum_next, sum_next[WIDTH-1],
                            a_reg[0], b_reg[0]);
    case (state_reg)
      ST_IDLE: if (in_valid) state_next = ST_RUN;
      ST_RUN:  if (last_bit) state_next = ST_DONE;
      ST_DONE: if (out_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg         <= '0;
      b_reg         <= '0;
      sum_reg       <= '0;
      carry_reg     <= 1'b0;
      bit_idx_reg   <= '0;
      out_reg       <= '0;
      carry_out_reg <= 1'b0;
      flags_reg     <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            a_reg       <= a;
            b_reg       <= b;
            carry_reg   <= cin;
            sum_reg     <= '0;
            bit_idx_reg <= '0;
          end
        end
        ST_RUN: begin
          a_reg       <= a_reg >> 1;
          b_reg       <= b_reg >> 1;
          carry_reg   <= cell_cout;
          sum_reg     <= sum_next;
          bit_idx_reg <= bit_idx_reg + IDX_W'(1);
          if (last_bit) begin
            out_reg       <= OUT_WIDTH'(sum_next);
            carry_out_reg <= cell_cout;
            flags_reg     <= flags_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign out      = out_reg;
  assign carry    = carry_out_reg;
  assign zero     = flags_reg.zero;
  assign parity   = flags_reg.parity;
  assign sign     = flags_reg.sign;
  assign overflow = flags_reg.overflow;

endmodule
